bus_target: RTL and testbench



---
 rtl/bus_target.sv | 249 ++++++++++++++++++++++++
 tb/tb_bus_target.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bus_target.sv
// bus_target: zero-wait-state responder for the CPU6 system bus.
// Serves on-board RAM from 0x0000 and one console channel (MUX0) with a
// TX FIFO and 8N1 transmitter. Define BUS_TARGET_RX_EN to build the 8N1
// receiver, RX holding register and the RXRDY/FRERR/RXOVR status bits.
// Bus handshake: no valid/ready; a write happens at every rising edge with
// writeEnBus=1, and dataInBus after edge N reflects the address and state
// present just before edge N.
module bus_target #(
  parameter int          RAM_ADDR_BITS = 14,
  parameter int          TX_DEPTH      = 4,
  parameter int          BAUD_DIV      = 16,
  parameter logic [15:0] MUX_BASE      = 16'hF200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  dataOutBus,
  input  logic        writeEnBus,
  output logic [7:0]  dataInBus,
  output logic        txd,
  input  logic        rxd
);

  localparam int PTR_W  = $clog2(TX_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [16:0]       RAM_SIZE  = 17'(1) << RAM_ADDR_BITS;
  localparam logic [15:0]       DATA_ADDR = MUX_BASE + 16'd1;
  localparam logic [CNT_W-1:0]  FIFO_CAP  = CNT_W'(TX_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} ser_state_e;

  // Address decode
  logic sel_ram, sel_stat, sel_data;
  logic wr_ram, wr_stat, wr_data;
  assign sel_ram  = ({1'b0, addressBus} < RAM_SIZE);
  assign sel_stat = (addressBus == MUX_BASE);
  assign sel_data = (addressBus == DATA_ADDR);
  assign wr_ram   = writeEnBus & sel_ram;
  assign wr_stat  = writeEnBus & sel_stat;
  assign wr_data  = writeEnBus & sel_data;

  // RAM: no reset, contents survive reset
  logic [7:0] ram_q [0:(1 << RAM_ADDR_BITS)-1];
  always_ff @(posedge clock) begin
    if (wr_ram) ram_q[addressBus[RAM_ADDR_BITS-1:0]] <= dataOutBus;
  end

  // TX FIFO
  logic [7:0]       fifo_q [0:TX_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full, fifo_empty, tx_pop, push_ok, tx_ovf_q;
  ser_state_e       tx_state_q;
  logic [BAUD_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_sh_q;
  logic             txd_q;

  assign fifo_full  = (count_q == FIFO_CAP);
  assign fifo_empty = (count_q == '0);
  // Pop in IDLE, or on the last STOP cycle so queued bytes go back-to-back
  assign tx_pop  = !fifo_empty && ((tx_state_q == ST_IDLE) ||
                   ((tx_state_q == ST_STOP) && (tx_cnt_q == BAUD_LAST)));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts
  assign push_ok = wr_data && (!fifo_full || tx_pop);

  // FIFO storage write
  always_ff @(posedge clock) begin
    if (push_ok) fifo_q[wr_ptr_q] <= dataOutBus;
  end

  // FIFO pointers, occupancy and sticky overflow flag (set wins over clear)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !tx_pop)      count_q <= count_q + CNT_W'(1);
      else if (!push_ok && tx_pop) count_q <= count_q - CNT_W'(1);
      tx_ovf_q <= (wr_data && !push_ok) | (tx_ovf_q & ~(wr_stat & dataOutBus[3]));
    end
  end

  // Transmitter FSM; txd is registered from the current state, so the line
  // lags the state by one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        ST_START: txd_q <= 1'b0;
        ST_DATA:  txd_q <= tx_sh_q[0];
        default:  txd_q <= 1'b1;
      endcase
      case (tx_state_q)
        ST_IDLE: begin
          if (tx_pop) begin
            tx_sh_q    <= fifo_q[rd_ptr_q];
            tx_cnt_q   <= '0;
            tx_state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= ST_DATA;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        ST_DATA: begin
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q <= '0;
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            if (tx_bit_q == 3'd7) tx_state_q <= ST_STOP;
            else                  tx_bit_q   <= tx_bit_q + 1'b1;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        default: begin
          if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_sh_q    <= fifo_q[rd_ptr_q];
              tx_state_q <= ST_START;
            end else tx_state_q <= ST_IDLE;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      endcase
    end
  end
  assign txd = txd_q;

  logic       rxrdy, frerr, rxovr;
  logic [7:0] rx_rdata;

`ifdef BUS_TARGET_RX_EN
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIV / 2 - 1);
  logic       rx_sync1_q, rx_sync2_q, rx_prev_q;
  ser_state_e rx_state_q;
  logic [BAUD_W-1:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q, rx_hold_q;
  logic       rxrdy_q, frerr_q, rxovr_q, rx_stop_ok, rx_stop_bad;

  assign rx_stop_ok  = (rx_state_q == ST_STOP) && (rx_cnt_q == BAUD_LAST) && rx_sync2_q;
  assign rx_stop_bad = (rx_state_q == ST_STOP) && (rx_cnt_q == BAUD_LAST) && !rx_sync2_q;

  // Receiver: synchronizer, edge detect and 8N1 sampling FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_sync1_q <= rxd;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      case (rx_state_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_sync2_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt_q == BAUD_HALF) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_state_q <= rx_sync2_q ? ST_IDLE : ST_DATA;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        ST_DATA: begin
          if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_sync2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: begin
          if (rx_cnt_q == BAUD_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= ST_IDLE;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
      endcase
    end
  end

  // RX holding register and sticky flags (set wins over write-1-to-clear)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_hold_q <= 8'h00;
      rxrdy_q   <= 1'b0;
      frerr_q   <= 1'b0;
      rxovr_q   <= 1'b0;
    end else begin
      if (rx_stop_ok) rx_hold_q <= rx_sh_q;
      rxrdy_q <= rx_stop_ok | (rxrdy_q & ~(wr_stat & dataOutBus[0]));
      frerr_q <= rx_stop_bad | (frerr_q & ~(wr_stat & dataOutBus[4]));
      rxovr_q <= (rx_stop_ok & rxrdy_q) | (rxovr_q & ~(wr_stat & dataOutBus[5]));
    end
  end

  assign rxrdy    = rxrdy_q;
  assign frerr    = frerr_q;
  assign rxovr    = rxovr_q;
  assign rx_rdata = rx_hold_q;
`else
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rxrdy      = 1'b0;
  assign frerr      = 1'b0;
  assign rxovr      = 1'b0;
  assign rx_rdata   = 8'hFF;
`endif

  // Read data mux, registered once
  logic [7:0] status_w, rdata_d, rdata_q;
  assign status_w = {2'b00, rxovr, frerr, tx_ovf_q,
                     (fifo_empty && (tx_state_q == ST_IDLE)), !fifo_full, rxrdy};
  always_comb begin
    rdata_d = 8'hFF;
    if (sel_ram)       rdata_d = ram_q[addressBus[RAM_ADDR_BITS-1:0]];
    else if (sel_stat) rdata_d = status_w;
    else if (sel_data) rdata_d = rx_rdata;
  end

  // Read data register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdata_q <= 8'hFF;
    else        rdata_q <= rdata_d;
  end
  assign dataInBus = rdata_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: RAM, TX frame, FIFO overflow, reset
// mid-frame, and RX paths when BUS_TARGET_RX_EN is defined.
module tb_bus_target;
  localparam int          BAUD_DIV = 16;
  localparam logic [15:0] STAT     = 16'hF200;
  localparam logic [15:0] DATA     = 16'hF201;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addressBus = 16'h0000;
  logic [7:0]  dataOutBus = 8'h00;
  logic        writeEnBus = 1'b0;
  logic [7:0]  dataInBus;
  logic        txd;
  logic        rxd = 1'b1;

  int tests = 0;
  int fails = 0;
  logic [7:0] rd;
  logic [9:0] frame;

  bus_target #(.RAM_ADDR_BITS(14), .TX_DEPTH(4), .BAUD_DIV(BAUD_DIV), .MUX_BASE(STAT)) dut (
    .clock(clock), .reset(reset), .addressBus(addressBus), .dataOutBus(dataOutBus),
    .writeEnBus(writeEnBus), .dataInBus(dataInBus), .txd(txd), .rxd(rxd)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addressBus = a; dataOutBus = d; writeEnBus = 1'b1;
    @(posedge clock); #1;
    writeEnBus = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
    @(negedge clock);
    addressBus = a; writeEnBus = 1'b0;
    @(posedge clock); #1;
    v = dataInBus;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); rxd = f[i];
      repeat (BAUD_DIV - 1) @(negedge clock);
    end
    @(negedge clock); rxd = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock); #1;
    check("reset_txd", {7'd0, txd}, 8'h01);
    check("reset_rdata", dataInBus, 8'hFF);
    @(negedge clock); reset = 1'b1;
    bus_read(STAT, rd); check("status_after_reset", rd, 8'h06);

    // RAM
    bus_write(16'h0123, 8'hA5);
    bus_read(16'h0123, rd); check("ram_0123", rd, 8'hA5);
    bus_read(16'h8000, rd); check("unmapped_8000", rd, 8'hFF);
    bus_write(16'h3FFF, 8'h5A);
    bus_read(16'h3FFF, rd); check("ram_top", rd, 8'h5A);
    bus_write(16'h4000, 8'h33);
    bus_read(16'h4000, rd); check("ram_end_unmapped", rd, 8'hFF);
    bus_write(16'h0124, 8'h11);
    bus_write(16'h0124, 8'h22);
    check("ram_same_cycle_old", dataInBus, 8'h11);
    bus_read(16'h0124, rd); check("ram_same_cycle_new", rd, 8'h22);

    // TX frame of 8'h4B
    frame = {1'b1, 8'h4B, 1'b0};
    bus_write(DATA, 8'h4B);
    addressBus = STAT;
    @(posedge clock); #1;
    check("tx_latency_hi", {7'd0, txd}, 8'h01);
    check("tx_status_busy", dataInBus, 8'h02);
    @(posedge clock);
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("tx_bit%0d_first", i), {7'd0, txd}, {7'd0, frame[i]});
      if (i == 5) check("tx_status_mid", dataInBus, 8'h02);
      repeat (BAUD_DIV - 1) @(posedge clock);
      #1 check($sformatf("tx_bit%0d_last", i), {7'd0, txd}, {7'd0, frame[i]});
      @(posedge clock);
    end
    #1;
    check("tx_idle_line", {7'd0, txd}, 8'h01);
    check("tx_status_done", dataInBus, 8'h06);

    // FIFO overflow: byte 1 to shifter, 2..5 fill FIFO, 6 dropped
    for (int i = 1; i <= 6; i++) bus_write(DATA, 8'(i));
    bus_read(STAT, rd); check("fifo_ovf_status", rd, 8'h08);
    bus_write(STAT, 8'h08);
    bus_read(STAT, rd); check("fifo_ovf_cleared", rd, 8'h00);
    // Push into full FIFO on the edge the next byte is popped
    repeat (152) @(posedge clock);
    bus_write(DATA, 8'h77);
    bus_read(STAT, rd); check("fifo_push_pop_full", rd, 8'h00);

    // Reset during frame bit 4 of byte 8'h02
    repeat (70) @(posedge clock);
    #1 check("tx_bit4_low", {7'd0, txd}, 8'h00);
    reset = 1'b0;
    #1;
    check("reset_mid_txd", {7'd0, txd}, 8'h01);
    check("reset_mid_rdata", dataInBus, 8'hFF);
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    bus_read(STAT, rd); check("status_after_mid_reset", rd, 8'h06);
    bus_read(16'h0123, rd); check("ram_kept", rd, 8'hA5);
    repeat (40) @(posedge clock);
    #1 check("txd_quiet_after_reset", {7'd0, txd}, 8'h01);
    bus_read(STAT, rd); check("status_still_idle", rd, 8'h06);

`ifdef BUS_TARGET_RX_EN
    bus_read(DATA, rd); check("rx_hold_reset", rd, 8'h00);
    send_byte(8'h3C, 1'b1);
    repeat (4) @(posedge clock);
    bus_read(STAT, rd); check("rx_rdy", rd, 8'h07);
    bus_read(DATA, rd); check("rx_data_3c", rd, 8'h3C);
    bus_read(STAT, rd); check("rx_read_no_side_effect", rd, 8'h07);
    send_byte(8'hA7, 1'b1);
    repeat (4) @(posedge clock);
    bus_read(STAT, rd); check("rx_overrun", rd, 8'h27);
    bus_read(DATA, rd); check("rx_data_a7", rd, 8'hA7);
    bus_write(STAT, 8'h21);
    bus_read(STAT, rd); check("rx_cleared", rd, 8'h06);
    send_byte(8'h55, 1'b0);
    repeat (4) @(posedge clock);
    bus_read(STAT, rd); check("rx_frerr", rd, 8'h16);
    bus_read(DATA, rd); check("rx_hold_unchanged", rd, 8'hA7);
    bus_write(STAT, 8'h10);
    // Short low pulse is rejected at the start-bit centre
    @(negedge clock); rxd = 1'b0;
    repeat (3) @(negedge clock); rxd = 1'b1;
    repeat (200) @(posedge clock);
    bus_read(STAT, rd); check("rx_glitch", rd, 8'h06);
`else
    send_byte(8'h3C, 1'b1);
    repeat (4) @(posedge clock);
    bus_read(STAT, rd); check("norx_status", rd, 8'h06);
    bus_read(DATA, rd); check("norx_data", rd, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
